// File: rtl/accum16_seq_if.sv
// Stream-side bundle for accum16_seq: burst request, word input stream and result output stream.
interface accum16_seq_if #(
   parameter int unsigned COUNT_W = 8
);
   logic               start;
   logic [COUNT_W-1:0] len;
   logic               in_valid;
   logic               in_ready;
   logic [15:0]        in_data;
   logic               out_valid;
   logic               out_ready;
   logic [15:0]        out_sum;
   logic               out_carry;
   logic               busy;

   modport master (
      output start, len, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_carry, busy
   );

   modport slave (
      input  start, len, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_carry, busy
   );
endinterface

// File: rtl/accum16_seq.sv
// Burst accumulator: sums len words through one fulladd16 stage, sticky carry-out flag.
// Optional macro ACCUM16_SATURATE_EN clamps the accumulator to 16'hFFFF on overflow.
module fulladd16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] sum,
   output logic        c_out
);
   always_comb begin
      logic [16:0] cy;
      cy    = '0;
      sum   = '0;
      cy[0] = c_in;
      for (int unsigned i = 0; i < 16; i++) begin
         sum[i]  = a[i] ^ b[i] ^ cy[i];
         cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
      end
      c_out = cy[16];
   end
endmodule

module accum16_seq #(
   parameter int unsigned COUNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   accum16_seq_if.slave        bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]         state;
   logic [15:0]        acc;
   logic               carry;
   logic [COUNT_W-1:0] remaining;
   logic [15:0]        add_sum;
   logic               add_cout;

   fulladd16 u_add (
      .a     (acc),
      .b     (bus.in_data),
      .c_in  (1'b0),
      .sum   (add_sum),
      .c_out (add_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         acc       <= '0;
         carry     <= 1'b0;
         remaining <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  remaining <= bus.len;
                  acc       <= '0;
                  carry     <= 1'b0;
                  state     <= (bus.len == '0) ? S_DONE : S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (bus.in_valid) begin
`ifdef ACCUM16_SATURATE_EN
                  // once clamped, further adds either carry again or add zero, so it stays at FFFF
                  acc <= add_cout ? '1 : add_sum;
`else
                  acc <= add_sum;
`endif
                  carry     <= carry | add_cout;
                  remaining <= remaining - COUNT_W'(1);
                  if (remaining == COUNT_W'(1))
                     state <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_ACCUM);
   assign bus.out_valid = (state == S_DONE);
   assign bus.out_sum   = acc;
   assign bus.out_carry = carry;
   assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_accum16_seq.sv
// Scoreboard bench for accum16_seq: directed bursts push expected results, a monitor checks each delivered result.
module tb_accum16_seq;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [16:0] exp_q[$];

   accum16_seq_if #(.COUNT_W(8)) bus ();

   accum16_seq #(.COUNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted result is compared against the oldest expectation.
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %0h/%0b, required no result", bus.out_sum, bus.out_carry);
            end else begin
               e = exp_q.pop_front();
               chk("result", {15'd0, bus.out_carry, bus.out_sum}, {15'd0, e});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] n);
      bus.start = 1'b1;
      bus.len   = n;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input int gap);
      bit got = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            got = 1;
            break;
         end
      end
      tick();
      bus.in_valid = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got in_ready=0 for 50 cycles, required 1");
      end
      repeat (gap) tick();
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d results pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit stop;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.len = '0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_sum", bus.out_sum, 0);
      chk("rst_out_carry", bus.out_carry, 0);
      chk("rst_busy", bus.busy, 0);
      #3 rst = 1'b0;
      tick();

      // reset mid-burst: two of four words taken, then aborted
      do_start(8'd4);
      send_word(16'h0005, 0);
      send_word(16'h0006, 0);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_in_ready", bus.in_ready, 0);
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_out_sum", bus.out_sum, 0);
      chk("abort_out_carry", bus.out_carry, 0);
      #1 rst = 1'b0;
      tick();
      exp_q.push_back({1'b0, 16'd3});
      do_start(8'd2);
      send_word(16'd1, 0);
      send_word(16'd2, 0);
      wait_drain("after_abort");

      // basic burst with out_ready already high
      exp_q.push_back({1'b0, 16'h0006});
      do_start(8'd3);
      chk("basic_in_ready", bus.in_ready, 1);
      send_word(16'h0001, 0);
      send_word(16'h0002, 0);
      send_word(16'h0003, 0);
      chk("basic_out_valid", bus.out_valid, 1);
      tick();
      chk("basic_busy_drop", bus.busy, 0);
      wait_drain("basic");

      // overflow
`ifdef ACCUM16_SATURATE_EN
      exp_q.push_back({1'b1, 16'hFFFF});
`else
      exp_q.push_back({1'b1, 16'h0001});
`endif
      do_start(8'd2);
      send_word(16'hFFFF, 0);
      send_word(16'h0002, 0);
      wait_drain("overflow");

      // stalls and backpressure; start in DONE must be ignored
      bus.out_ready = 1'b0;
      exp_q.push_back({1'b0, 16'h2345});
      do_start(8'd2);
      send_word(16'h1234, 3);
      send_word(16'h1111, 0);
      for (int i = 0; i < 5; i++) begin
         bus.start = (i == 2);
         bus.len   = 8'd5;
         chk("hold_out_valid", bus.out_valid, 1);
         chk("hold_out_sum", bus.out_sum, 16'h2345);
         tick();
      end
      bus.start = 1'b0;
      chk("hold_after_start", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      bus.len = 8'd3;
      tick();
      bus.start = 1'b0;
      chk("accept_start_ignored", bus.busy, 0);
      tick();
      chk("start_not_queued", bus.busy, 0);
      wait_drain("backpressure");

      // zero length, upstream offering a word that must not be taken
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h5555;
      exp_q.push_back({1'b0, 16'h0000});
      do_start(8'd0);
      chk("zero_out_valid", bus.out_valid, 1);
      chk("zero_in_ready", bus.in_ready, 0);
      tick();
      chk("zero_in_ready_after", bus.in_ready, 0);
      chk("zero_busy", bus.busy, 0);
      bus.in_valid = 1'b0;
      wait_drain("zero");

      // cross-check all 4-bit pairs; stop at the first error
      stop = 0;
      for (int a = 0; a < 16 && !stop; a++) begin
         for (int b = 0; b < 16 && !stop; b++) begin
            exp_q.push_back({1'b0, 16'(a + b)});
            do_start(8'd2);
            send_word(16'(a), 0);
            send_word(16'(b), 0);
            wait_drain("cross");
            if (errors != 0) stop = 1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/accum16_seq.md
# accum16_seq

Sequential operand accumulator that drives the `fulladd16` combinational adder stage. It accepts a burst of `len` 16-bit words over a valid/ready stream and sums them in a register, one word per clock. Each step feeds the running total and the incoming word through one `fulladd16` instance. The final sum and a sticky carry-out flag go to a downstream consumer over a second valid/ready handshake.

## Interface
Parameters:
- `COUNT_W`, default 8: width of the burst-length counter. Maximum burst is 2^COUNT_W − 1 words.

Ports:
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- `len`  input  COUNT_W  number of words in the burst; latched when `start` is accepted.
- `in_valid`  input  1  upstream word present on `in_data`.
- `in_ready`  output  1  block accepts `in_data` this cycle.
- `in_data`  input  16  operand word.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  downstream accepts the result.
- `out_sum`  output  16  accumulated sum.
- `out_carry`  output  1  sticky: set if any add in the burst produced `c_out`=1.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- The block has one `fulladd16` instance with these connections: `a` = accumulator register, `b` = `in_data`, `c_in` = 0. The sum and `c_out` feed the register update.
- The FSM has three states: IDLE, ACCUM and DONE.
- **IDLE**
  - `start`=1 latches `len` into `remaining`, clears the accumulator and clears the carry flag.
  - If `len`≠0, the next state is ACCUM. If `len`=0, the next state is DONE with sum 0 and carry 0.
- **ACCUM**
  - `in_ready`=1.
  - On each beat (`in_valid`&&`in_ready`): accumulator ← adder sum, carry flag ← carry flag | `c_out`, and `remaining` decrements by 1.
  - When the beat occurs with `remaining`=1, the next state is DONE.
  - Cycles with `in_valid`=0 make no change.
- **DONE**
  - `out_valid`=1. `out_sum` and `out_carry` are driven directly from the registers and stay stable until accepted.
  - `out_valid`&&`out_ready` returns the FSM to IDLE. The registers keep their values until the next `start`.
- `start` in ACCUM or DONE is ignored. It is not queued.
- `in_ready`=0 in IDLE and DONE, so upstream words are not consumed there.
- Arithmetic is modulo 2^16. The carry is never fed back into the next add.

## Timing
- Reset values: state=IDLE, accumulator=0, carry flag=0, `remaining`=0, `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_carry`=0, `busy`=0.
- Reset asserted mid-burst aborts at once, asynchronously. Any partially accepted words are discarded.
- Cycle k: `start` sampled. From cycle k+1: `in_ready`=1 (or `out_valid`=1 if `len`=0).
- A burst of N words with `in_valid` held high takes N cycles in ACCUM. `out_valid` rises in the cycle after the last beat.
- `out_ready` may already be high when `out_valid` rises. The result is then accepted in that same cycle, and `busy` drops the following cycle.
- If `start` and `out_ready` arrive in the same cycle in DONE, the return to IDLE takes effect and `start` is ignored.
- Minimum start-to-start spacing is N+2 cycles.
- The adder path is combinational, so a single-cycle `fulladd16` evaluation is required at the target clock.

## Configuration
- Macro: `ACCUM16_SATURATE_EN`.
- **Defined:** on any beat where `c_out`=1, the accumulator loads 16'hFFFF instead of the wrapped sum. It then stays at 16'hFFFF for the rest of the burst, and `out_carry` is still set.
- **Undefined:** the sum wraps modulo 2^16. `out_carry` only flags that an overflow occurred.

## Test plan
- Reset mid-burst: `len`=4, 2 words accepted, then `rst` pulse → all outputs 0, state IDLE. A new `start` with words 1,2 → `out_sum`=3.
- Basic burst: `len`=3, words 16'h0001, 16'h0002, 16'h0003 sent back-to-back → `out_valid` one cycle after the 3rd beat, `out_sum`=16'h0006, `out_carry`=0.
- Overflow: `len`=2, words 16'hFFFF, 16'h0002.
  - Without `ACCUM16_SATURATE_EN` → `out_sum`=16'h0001, `out_carry`=1.
  - With it → `out_sum`=16'hFFFF, `out_carry`=1.
- Stalls and backpressure: `len`=2, `in_valid` gaps of 3 cycles, `out_ready` held low for 5 cycles → `out_sum`=sum of the words held stable, `out_valid` high throughout, no `start` accepted.
- Zero length: `start` with `len`=0 → `out_valid` next cycle, `out_sum`=0, `out_carry`=0, `in_ready` never asserted.
- Exhaustive cross-check: for all a,b in 0..15, run `len`=2 with words a,b → `out_sum`=a+b. Any mismatch stops the bench.
